alu_issue: RTL
==============

# alu_issue

Operand-issue and writeback stage directly upstream of the 16-bit ALU. Owns the general-purpose register file, accepts decoded two-operand instructions over a valid/ready handshake, and registers the ALU operand, opcode and flag-enable signals. It writes the ALU result back to the destination register one cycle later and forwards that result to a dependent instruction accepted in the same cycle.

## Interface
- `WIDTH`, 16: datapath width.
- `REGS`, 16: register count; register index width is log2(`REGS`).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `dec_valid`  in  1  decoded instruction present.
- `dec_ready`  out  1  stage accepts the instruction this cycle.
- `dec_op`  in  4  ALU opcode: [2:0] 000 add, 001 and, 010 or, 011 xor, other values give a zero result; [3] subtract (add only).
- `dec_rd`  in  log2(REGS)  destination and first-source register.
- `dec_rs`  in  log2(REGS)  second-source register.
- `dec_imm`  in  WIDTH  immediate operand.
- `dec_use_imm`  in  1  second operand is `dec_imm` instead of `rf[dec_rs]`.
- `dec_wb`  in  1  write the result back; 0 gives a compare-style, flags-only operation.
- `dec_setflags`  in  1  update the ALU flags.
- `hold`  in  1  freeze the execute slot.
- `reg1`, `reg2`  out  WIDTH  ALU operands, driven directly from registers.
- `inst`  out  4  ALU opcode, driven directly from a register.
- `flagWrite`  out  1  ALU flag-update enable.
- `result`  in  WIDTH  combinational ALU result.
- `dbg_addr`  in  log2(REGS)  debug read address.
- `dbg_data`  out  WIDTH  combinational `rf[dbg_addr]`.

## Operation
- Single execute slot holds `ex_valid`, `ex_rd`, `ex_wb`, `ex_setflags`, operands and opcode.
- Accept: `dec_valid & dec_ready`. `dec_ready = ~hold` (with forwarding compiled in).
- On accept the slot loads:
  - `reg1 ← rf[dec_rd]`.
  - `reg2 ← dec_use_imm ? dec_imm : rf[dec_rs]`.
  - `inst ← dec_op`.
  - `ex_valid ← 1`.
- No accept and no `hold`: `ex_valid ← 0`. `reg1`, `reg2` and `inst` keep their values.
- `flagWrite = ex_valid & ex_setflags & ~hold`.
- Writeback at the rising edge ending a valid execute cycle: `rf[ex_rd] ← result`, only when `ex_wb & ~hold & ex_rd != 0`.
- Register 0 always reads zero. Writes to register 0 are dropped.
- Forwarding: an operand whose source index equals `ex_rd` while a writeback is pending captures `result` instead of the register-file value. This applies to `reg1` and to a non-immediate `reg2`.
- `hold` asserted:
  - Slot, register file and outputs are frozen.
  - No accept and no writeback.
  - The slot completes normally in the first cycle after `hold` drops.
- No arithmetic in this block. Widths pass through unchanged.

## Timing
- Reset values:
  - All `rf` entries 0.
  - `ex_valid`, `ex_wb` and `ex_setflags` 0.
  - `reg1`, `reg2` and `inst` 0.
  - `flagWrite` 0.
  - `dec_ready` = `~hold`.
- Instruction accepted at edge N:
  - Operands valid during cycle N+1.
  - ALU flags update at the falling edge inside N+1.
  - Writeback at edge N+2.
  - Latency 2; throughput 1 per cycle.
- Back-to-back dependent instructions issue without a bubble when forwarding is compiled in.
- Writeback and debug read to the same register in one cycle: `dbg_data` shows the old value until the edge.
- Reset mid-operation discards the slot. No writeback occurs.

## Configuration
- `ALU_ISSUE_FWD_EN` defined: forwarding as described above; `dec_ready = ~hold`.
- Not defined: no bypass path. `dec_ready` is 0 while all of the following hold:
  - `ex_valid & ex_wb & ex_rd != 0`;
  - `dec_valid`;
  - `dec_rd == ex_rd`, or `dec_rs == ex_rd` with `~dec_use_imm`.
- In that case exactly one bubble is inserted, then the instruction issues reading the written-back value.

## Structure
- Shared CPU package holds:
  - ALU opcode constants (`ADD`, `AND`, `OR`, `XOR`, `SUB` bit);
  - `WIDTH`, `REGS`;
  - the register-index type.
- One sub-module, `regfile`: two combinational read ports plus debug port, one synchronous write port, register 0 hard-wired to zero, asynchronous reset.
- Slot, handshake and bypass logic stay in `alu_issue`.

## Test plan
- Reset, then read all registers via `dbg_addr` → every `dbg_data` = 0; `flagWrite` = 0; `dec_ready` = 1.
- Accept add r1, imm 5, then add r2, imm 0x0007 → at edge N+2, `rf[1]` = 0x0005 and `rf[2]` = 0x0007.
- r1 = 3; issue add r1, r1 immediately followed by add r1, r1 → `rf[1]` = 6 then 12. With forwarding: no bubble. Without the macro: one cycle with `dec_ready` = 0.
- Compare op (`dec_wb` = 0, `dec_setflags` = 1, subtract) r2 = 7 vs imm 7 → `flagWrite` = 1 for one cycle; `rf[2]` unchanged.
- Write 0xFFFF to r0 → `dbg_data` for r0 stays 0; a dependent read of r0 gives `reg1` = 0, with no forwarding.
- Assert `hold` for 3 cycles with a valid slot and `dec_valid` = 1 → `flagWrite` = 0, no writeback, `dec_ready` = 0. Release → writeback one edge later, then the pending instruction is accepted.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared CPU definitions for the operand-issue stage.
//   WIDTH     datapath width
//   REGS      register count
//   IDX_W     register index width, log2(REGS)
//   reg_idx_t register index type
//   ALU_*     opcode field values for dec_op[2:0]
//   ALU_SUB_BIT  dec_op bit that turns add into subtract
package alu_issue_pkg;

  localparam int WIDTH = 16;
  localparam int REGS  = 16;
  localparam int IDX_W = $clog2(REGS);

  typedef logic [IDX_W-1:0] reg_idx_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam int         ALU_SUB_BIT = 3;

endpackage

// File: rtl/alu_issue_regfile.sv
// alu_issue_regfile: general-purpose register file for the issue stage.
//   clk, reset        clock, asynchronous active-high reset (all entries 0)
//   ra_addr/ra_data   combinational read port A
//   rb_addr/rb_data   combinational read port B
//   dbg_addr/dbg_data combinational debug read port
//   we, wa, wd        synchronous write port
// Register 0 is hard-wired to zero; writes to it are dropped.
module alu_issue_regfile
  import alu_issue_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] ra_addr,
  output logic [WIDTH-1:0] ra_data,
  input  logic [IDX_W-1:0] rb_addr,
  output logic [WIDTH-1:0] rb_data,
  input  logic [IDX_W-1:0] dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  input  logic             we,
  input  logic [IDX_W-1:0] wa,
  input  logic [WIDTH-1:0] wd
);

  logic [WIDTH-1:0] mem [REGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REGS; i++) mem[i] <= '0;
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  // Reads see the pre-edge contents; a same-cycle write is visible only after the edge.
  assign ra_data  = (ra_addr  == '0) ? '0 : mem[ra_addr];
  assign rb_data  = (rb_addr  == '0) ? '0 : mem[rb_addr];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// alu_issue: operand-issue and writeback stage in front of the 16-bit ALU.
// Owns the register file, accepts decoded two-operand instructions over a
// valid/ready handshake, registers ALU operands/opcode and writes the ALU
// result back one cycle later.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   dec_valid/dec_ready  decode handshake
//   dec_op               [2:0] ALU function, [3] subtract
//   dec_rd, dec_rs       destination/first source, second source
//   dec_imm, dec_use_imm immediate and its select for the second operand
//   dec_wb, dec_setflags writeback enable, flag-update enable
//   hold                 freeze the execute slot
//   reg1, reg2, inst     registered ALU operands and opcode
//   flagWrite            ALU flag-update enable
//   result               combinational ALU result
//   dbg_addr, dbg_data   debug register read
// Build option: ALU_ISSUE_FWD_EN enables the result bypass into the operand
// muxes; without it a dependent instruction is stalled for one bubble.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [3:0]       dec_op,
  input  logic [IDX_W-1:0] dec_rd,
  input  logic [IDX_W-1:0] dec_rs,
  input  logic [WIDTH-1:0] dec_imm,
  input  logic             dec_use_imm,
  input  logic             dec_wb,
  input  logic             dec_setflags,
  input  logic             hold,
  output logic [WIDTH-1:0] reg1,
  output logic [WIDTH-1:0] reg2,
  output logic [3:0]       inst,
  output logic             flagWrite,
  input  logic [WIDTH-1:0] result,
  input  logic [IDX_W-1:0] dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic             ex_valid;
  logic             ex_wb;
  logic             ex_setflags;
  logic [IDX_W-1:0] ex_rd;

  logic [WIDTH-1:0] rf_a;
  logic [WIDTH-1:0] rf_b;
  logic [WIDTH-1:0] opnd_a;
  logic [WIDTH-1:0] opnd_b;
  logic             wb_pend;
  logic             wb_en;
  logic             accept;

  // A writeback is owed at the next unheld edge; r0 targets never count.
  assign wb_pend = ex_valid & ex_wb & (ex_rd != '0);
  assign wb_en   = wb_pend & ~hold;
  assign accept  = dec_valid & dec_ready;

  alu_issue_regfile regfile (
    .clk      (clk),
    .reset    (reset),
    .ra_addr  (dec_rd),
    .ra_data  (rf_a),
    .rb_addr  (dec_rs),
    .rb_data  (rf_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (wb_en),
    .wa       (ex_rd),
    .wd       (result)
  );

`ifdef ALU_ISSUE_FWD_EN
  logic fwd_a;
  logic fwd_b;

  // Accept implies ~hold, so the pending writeback lands on the same edge
  // that captures the operand: take the ALU result instead of the stale rf value.
  assign fwd_a     = wb_pend & (dec_rd == ex_rd);
  assign fwd_b     = wb_pend & (dec_rs == ex_rd);
  assign opnd_a    = fwd_a ? result : rf_a;
  assign opnd_b    = dec_use_imm ? dec_imm : (fwd_b ? result : rf_b);
  assign dec_ready = ~hold;
`else
  logic hazard;

  // No bypass: a reader of the register being written waits one cycle and
  // then picks up the written-back value from the register file.
  assign hazard    = wb_pend & dec_valid &
                     ((dec_rd == ex_rd) | ((dec_rs == ex_rd) & ~dec_use_imm));
  assign opnd_a    = rf_a;
  assign opnd_b    = dec_use_imm ? dec_imm : rf_b;
  assign dec_ready = ~hold & ~hazard;
`endif

  // Execute slot: loaded on accept, emptied on an idle unheld cycle, frozen on hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_wb       <= 1'b0;
      ex_setflags <= 1'b0;
      ex_rd       <= '0;
      reg1        <= '0;
      reg2        <= '0;
      inst        <= '0;
    end else if (!hold) begin
      if (accept) begin
        ex_valid    <= 1'b1;
        ex_wb       <= dec_wb;
        ex_setflags <= dec_setflags;
        ex_rd       <= dec_rd;
        reg1        <= opnd_a;
        reg2        <= opnd_b;
        inst        <= dec_op;
      end else begin
        ex_valid <= 1'b0;
      end
    end
  end

  assign flagWrite = ex_valid & ex_setflags & ~hold;

endmodule
